line_window_scheduler: RTL and testbench

Controller that sequences a three-bank row buffer for the convolution stage. It accepts input rows from the upstream producer and assigns each to a buffer bank. For every output row it presents K channel-slice windows to the downstream convolution engine, one at a time, each with top/mid/bottom bank selects and zero-pad flags. It waits for the engine's completion pulse between windows and signals end of frame. It sits between the row producer and the line-buffer/convolution datapath and owns all of that datapath's write enables, pointers and slice indices.

---
 rtl/line_sched_pkg.sv | 14 +
 rtl/bank_rotator.sv | 39 +++
 rtl/line_window_scheduler.sv | 137 +++++++++++++
 tb/tb_line_window_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_sched_pkg.sv
// Shared types for the line window scheduler: FSM states, bank index and
// the modulo-3 step used for every bank pointer.
package line_sched_pkg;

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, LOAD, DONE} state_t;

  typedef logic [1:0] bank_t;

  // 0 -> 1 -> 2 -> 0
  function automatic bank_t inc3(input bank_t b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

endpackage

// File: rtl/bank_rotator.sv
// Bank pointers for the three-bank row buffer: the write pointer follows
// accepted rows, the mid pointer follows the current output row. Window
// selects are forced to 0 whenever no window is active.
module bank_rotator
  import line_sched_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       wr_adv,
  input  logic       row_adv,
  input  logic       en,
  output logic [1:0] wr_bank,
  output logic [1:0] top_sel,
  output logic [1:0] mid_sel,
  output logic [1:0] bot_sel
);

  bank_t wp;
  bank_t mp;

  // advance write pointer per accepted row, mid pointer per output-row step
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      wp <= 2'd0;
      mp <= 2'd0;
    end else begin
      if (wr_adv)  wp <= inc3(wp);
      if (row_adv) mp <= inc3(mp);
    end
  end

  assign wr_bank = wp;
  assign mid_sel = en ? mp : 2'd0;
  assign bot_sel = en ? inc3(mp) : 2'd0;
  // (r-1) mod 3 is two forward steps
  assign top_sel = en ? inc3(inc3(mp)) : 2'd0;

endmodule

// File: rtl/line_window_scheduler.sv
// Sequences a three-bank row buffer: takes H rows per frame, issues K
// channel-slice windows per output row, waits for conv completion between
// windows and pulses frame_done_o at the end of the frame.
// Optional STALL_CNT_EN adds a saturating 16-bit stall counter output.
module line_window_scheduler
  import line_sched_pkg::*;
#(
  parameter int H  = 24,
  parameter int K  = 6,
  parameter int RW = $clog2(H+1),
  parameter int SW = $clog2(K+1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          row_valid_i,
  output logic          row_ready_o,
  output logic          wr_en_o,
  output logic [1:0]    wr_bank_o,
  output logic          win_valid_o,
  input  logic          win_ready_i,
  input  logic          conv_done_i,
  output logic [1:0]    top_sel_o,
  output logic [1:0]    mid_sel_o,
  output logic [1:0]    bot_sel_o,
  output logic          pad_top_o,
  output logic          pad_bot_o,
  output logic [SW-1:0] slice_o,
  output logic [RW-1:0] out_row_o,
  output logic          frame_done_o
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o
`endif
);

  localparam logic [RW-1:0] R_LAST = RW'(H-1);
  localparam logic [SW-1:0] S_LAST = SW'(K-1);

  state_t        st, st_nxt;
  logic [RW-1:0] row_q, row_nxt;
  logic [SW-1:0] slc_q, slc_nxt;
  logic          accept, row_adv, win_act;

  assign row_ready_o  = (st == IDLE) || (st == FILL) || (st == LOAD);
  assign accept       = row_valid_i & row_ready_o;
  assign wr_en_o      = accept;
  assign win_valid_o  = (st == ISSUE);
  assign frame_done_o = (st == DONE);
  assign win_act      = (st == ISSUE) || (st == WAIT) || (st == LOAD);
  assign pad_top_o    = win_act && (row_q == '0);
  assign pad_bot_o    = win_act && (row_q == R_LAST);
  assign slice_o      = slc_q;
  assign out_row_o    = row_q;

  // next state, row and slice; row_adv steps the mid bank pointer
  always_comb begin
    st_nxt  = st;
    row_nxt = row_q;
    slc_nxt = slc_q;
    row_adv = 1'b0;
    case (st)
      IDLE:  if (accept) st_nxt = FILL;
      FILL:  if (accept) st_nxt = ISSUE;
      ISSUE: if (win_ready_i) st_nxt = WAIT;
      WAIT: begin
        if (conv_done_i) begin
          if (slc_q != S_LAST) begin
            slc_nxt = slc_q + SW'(1);
            st_nxt  = ISSUE;
          end else begin
            slc_nxt = '0;
            if (row_q == R_LAST) begin
              st_nxt = DONE;
            end else begin
              row_nxt = row_q + RW'(1);
              row_adv = 1'b1;
              // the new bottom row still has to be fetched unless it is padding
              st_nxt  = ((row_q + RW'(2)) <= R_LAST) ? LOAD : ISSUE;
            end
          end
        end
      end
      LOAD:  if (accept) st_nxt = ISSUE;
      DONE: begin
        st_nxt  = IDLE;
        row_nxt = '0;
        slc_nxt = '0;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st    <= IDLE;
      row_q <= '0;
      slc_q <= '0;
    end else begin
      st    <= st_nxt;
      row_q <= row_nxt;
      slc_q <= slc_nxt;
    end
  end

  bank_rotator u_rot (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (st == DONE),
    .wr_adv  (accept),
    .row_adv (row_adv),
    .en      (win_act),
    .wr_bank (wr_bank_o),
    .top_sel (top_sel_o),
    .mid_sel (mid_sel_o),
    .bot_sel (bot_sel_o)
  );

`ifdef STALL_CNT_EN
  logic [15:0] stall_q;

  // count engine back-pressure in ISSUE and producer starvation in LOAD
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (st == IDLE && accept) begin
      stall_q <= '0;
    end else if (((st == ISSUE && !win_ready_i) || (st == LOAD && !row_valid_i))
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_line_window_scheduler.sv
// Randomized bench for line_window_scheduler (H=4, K=2). The reference is
// the per-frame event order (row writes and window handshakes) derived from
// the frame rules, compared event by event as the DUT produces them.
module tb_line_window_scheduler;

  localparam int H  = 4;
  localparam int K  = 2;
  localparam int RW = $clog2(H+1);
  localparam int SW = $clog2(K+1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          row_valid_i = 1'b0;
  logic          win_ready_i = 1'b0;
  logic          conv_done_i = 1'b0;
  logic          row_ready_o, wr_en_o, win_valid_o;
  logic          pad_top_o, pad_bot_o, frame_done_o;
  logic [1:0]    wr_bank_o, top_sel_o, mid_sel_o, bot_sel_o;
  logic [SW-1:0] slice_o;
  logic [RW-1:0] out_row_o;
`ifdef STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  line_window_scheduler #(.H(H), .K(K)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .row_valid_i  (row_valid_i),
    .row_ready_o  (row_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_bank_o    (wr_bank_o),
    .win_valid_o  (win_valid_o),
    .win_ready_i  (win_ready_i),
    .conv_done_i  (conv_done_i),
    .top_sel_o    (top_sel_o),
    .mid_sel_o    (mid_sel_o),
    .bot_sel_o    (bot_sel_o),
    .pad_top_o    (pad_top_o),
    .pad_bot_o    (pad_bot_o),
    .slice_o      (slice_o),
    .out_row_o    (out_row_o),
    .frame_done_o (frame_done_o)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // expected frame: rows 0,1 up front; after output row r finishes, row r+2
  // is fetched if it exists
  typedef struct {bit win; int a; int b;} ev_t;
  ev_t exp_q[$];

  function automatic void build_frame();
    ev_t e;
    exp_q.delete();
    for (int n = 0; n < 2; n++) begin
      e.win = 1'b0; e.a = n; e.b = 0; exp_q.push_back(e);
    end
    for (int r = 0; r < H; r++) begin
      for (int s = 0; s < K; s++) begin
        e.win = 1'b1; e.a = r; e.b = s; exp_q.push_back(e);
      end
      if (r + 2 <= H - 1) begin
        e.win = 1'b0; e.a = r + 2; e.b = 0; exp_q.push_back(e);
      end
    end
  endfunction

  int            cd = 0;
  int            hold = 0;
  bit            hold_req = 1'b0;
  bit            prev_stall = 1'b0;
  bit            prev_fd = 1'b0;
  int            prev_slice = 0;
  int            prev_row = 0;
  int            frames = 0;
  int            win_in_frame = 0;
  int            stall_exp = 0;

  task automatic check_reset_vals();
    chk("rst_row_ready", int'(row_ready_o), 1);
    chk("rst_wr_en", int'(wr_en_o), 0);
    chk("rst_wr_bank", int'(wr_bank_o), 0);
    chk("rst_win_valid", int'(win_valid_o), 0);
    chk("rst_top_sel", int'(top_sel_o), 0);
    chk("rst_mid_sel", int'(mid_sel_o), 0);
    chk("rst_bot_sel", int'(bot_sel_o), 0);
    chk("rst_pad_top", int'(pad_top_o), 0);
    chk("rst_pad_bot", int'(pad_bot_o), 0);
    chk("rst_slice", int'(slice_o), 0);
    chk("rst_out_row", int'(out_row_o), 0);
    chk("rst_frame_done", int'(frame_done_o), 0);
`ifdef STALL_CNT_EN
    chk("rst_stall_cnt", int'(stall_cnt_o), 0);
`endif
  endtask

  // one clock: check Moore outputs, drive random inputs, check handshakes
  task automatic cycle();
    ev_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", int'(win_valid_o), 1);
      chk("hold_slice", int'(slice_o), prev_slice);
      chk("hold_row", int'(out_row_o), prev_row);
    end
    if (prev_fd) begin
      chk("fd_single", int'(frame_done_o), 0);
      chk("ready_after_done", int'(row_ready_o), 1);
    end
    if (frame_done_o) begin
      chk("fd_events_left", exp_q.size(), 0);
`ifdef STALL_CNT_EN
      chk("stall_cnt", int'(stall_cnt_o), stall_exp);
`endif
      frames++;
      build_frame();
      win_in_frame = 0;
    end

    row_valid_i = ($urandom_range(0, 99) < 50);
    if (win_valid_o && hold_req) begin
      hold = 5;
      hold_req = 1'b0;
    end
    if (hold > 0) begin
      win_ready_i = 1'b0;
      hold--;
    end else begin
      win_ready_i = ($urandom_range(0, 99) < 60);
    end
    conv_done_i = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) conv_done_i = 1'b1;
    end else if ($urandom_range(0, 9) == 0) begin
      conv_done_i = 1'b1;  // spurious: never while a window is outstanding
    end
    #1;

    if (win_valid_o && !win_ready_i) stall_exp++;
    if (row_ready_o && win_in_frame > 0 && !row_valid_i) stall_exp++;

    if (wr_en_o) begin
      chk("wr_en_needs_valid", int'(row_valid_i), 1);
      chk("row_event_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("row_order", int'(e.win), 0);
        chk("wr_bank", int'(wr_bank_o), e.a % 3);
        if (e.a == 0) stall_exp = 0;
      end
    end

    if (win_valid_o && win_ready_i) begin
      chk("win_event_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("win_order", int'(e.win), 1);
        chk("out_row", int'(out_row_o), e.a);
        chk("slice", int'(slice_o), e.b);
        chk("pad_top", int'(pad_top_o), int'(e.a == 0));
        chk("pad_bot", int'(pad_bot_o), int'(e.a == H - 1));
        if (e.a != 0) chk("top_sel", int'(top_sel_o), (e.a + 2) % 3);
        chk("mid_sel", int'(mid_sel_o), e.a % 3);
        if (e.a != H - 1) chk("bot_sel", int'(bot_sel_o), (e.a + 1) % 3);
      end
      cd = $urandom_range(1, 3);
      win_in_frame++;
    end

    prev_stall = win_valid_o && !win_ready_i;
    prev_slice = int'(slice_o);
    prev_row   = int'(out_row_o);
    prev_fd    = frame_done_o;
  endtask

  task automatic run_frames(input int n);
    int tgt;
    int budget;
    tgt = frames + n;
    budget = 2000 * n;
    while (frames < tgt && budget > 0) begin
      cycle();
      budget--;
    end
    chk("frames_completed", frames, tgt);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    row_valid_i = 1'b0;
    win_ready_i = 1'b0;
    conv_done_i = 1'b0;
    @(negedge clk);
    check_reset_vals();
    resetn = 1'b1;
    cd = 0;
    hold = 0;
    prev_stall = 1'b0;
    prev_fd = 1'b0;
    win_in_frame = 0;
    stall_exp = 0;
    build_frame();
  endtask

  initial begin
    int b;
    apply_reset();
    hold_req = 1'b1;
    run_frames(3);

    // stop inside WAIT of output row 2, then reset mid-frame
    b = 2000;
    while (!(cd > 0 && out_row_o == RW'(2)) && b > 0) begin
      cycle();
      b--;
    end
    chk("reach_r2_wait", int'(cd > 0 && out_row_o == RW'(2)), 1);
    @(posedge clk);
    apply_reset();
    hold_req = 1'b1;
    run_frames(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
